uart_retrans_tx: RTL and testbench

Serial transmitter with retransmission, upstream of the receive-side retransmission block. It accepts a byte, frames it (start, 8 data bits LSB first, even parity, stop) and drives it onto the serial line. It then waits for the receiver's `ack` or `request_resend` and retransmits on request, up to a bounded number of retries. It reports delivery (`done`) or give-up (`fail`) to the local producer.

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_tx_bitclk.sv | 37 +++
 rtl/uart_retrans_tx.sv | 181 ++++++++++++++++++
 tb/tb_uart_retrans_tx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the retransmitting UART transmitter.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_RESP,
      DONE,
      FAIL
   } tx_state_t;

   localparam int   FRAME_BITS = 11;
   localparam int   DATA_BITS  = 8;
   localparam logic LINE_IDLE  = 1'b1;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_tx_bitclk.sv
// Bit-period down-counter: holds at reload while idle and ticks on the last
// cycle of every serial bit while the transmit path is running.
module uart_tx_bitclk
   import uart_tx_pkg::*;
#(
   parameter int BIT_CYCLES = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic bit_tick
);

   localparam logic [7:0] RELOAD = 8'(BIT_CYCLES - 1);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!run || cnt_q == '0) begin
         cnt_d = RELOAD;
      end else begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_tick = run && (cnt_q == '0);

endmodule

// File: rtl/uart_retrans_tx.sv
// Framed serial transmitter (start, 8 data LSB first, even parity, stop) with
// ack/resend handling and bounded retries. `UART_TX_FAULT_INJECT_EN adds inject_err.
module uart_retrans_tx
   import uart_tx_pkg::*;
#(
   parameter int BIT_CYCLES   = 1,
   parameter int MAX_RETRY    = 4,
   parameter int RESP_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       send,
   input  logic       ack,
   input  logic       request_resend,
`ifdef UART_TX_FAULT_INJECT_EN
   input  logic       inject_err,
`endif
   output logic       signal,
   output logic       busy,
   output logic       done,
   output logic       fail,
   output logic [2:0] retry_count
);

   localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);
   localparam logic [7:0] TIMEOUT   = 8'(RESP_TIMEOUT);
   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

   tx_state_t  state_q, state_d;
   logic [7:0] frame_q, frame_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [2:0] retry_q, retry_d;
   logic [7:0] timer_q, timer_d;
   logic       signal_q, signal_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       fail_q, fail_d;
   logic       flip;
   logic       bit_run;
   logic       bit_tick;

`ifdef UART_TX_FAULT_INJECT_EN
   logic       fault_q, fault_d;
`endif

   assign bit_run = state_q inside {START, DATA, PARITY, STOP};

   uart_tx_bitclk #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_bitclk (
      .clk     (clk),
      .reset   (reset),
      .run     (bit_run),
      .bit_tick(bit_tick)
   );

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      bit_idx_d = bit_idx_q;
      retry_d   = retry_q;
      timer_d   = timer_q;
`ifdef UART_TX_FAULT_INJECT_EN
      fault_d   = fault_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (send) begin
               frame_d   = data_in;
               retry_d   = '0;
               bit_idx_d = '0;
               state_d   = START;
`ifdef UART_TX_FAULT_INJECT_EN
               fault_d   = inject_err;
`endif
            end
         end
         START: begin
            if (bit_tick) begin
               bit_idx_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (bit_tick) begin
               if (bit_idx_q == LAST_BIT) begin
                  state_d = PARITY;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_tick) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_tick) begin
               timer_d = '0;
               state_d = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            // timer_d is the 1-based count of WAIT_RESP cycles including this one
            timer_d = timer_q + 8'd1;
            if (ack) begin
               state_d = DONE;
            end else if (request_resend || timer_d == TIMEOUT) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d   = retry_q + 3'd1;
                  bit_idx_d = '0;
                  state_d   = START;
               end else begin
                  state_d = FAIL;
               end
            end
         end
         DONE:    state_d = IDLE;
         FAIL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

`ifdef UART_TX_FAULT_INJECT_EN
      flip = fault_d && (retry_d == '0);
`else
      flip = 1'b0;
`endif

      // Outputs are decoded from the next state so they register alongside it
      signal_d = LINE_IDLE;
      unique case (state_d)
         START:   signal_d = 1'b0;
         DATA:    signal_d = frame_d[bit_idx_d];
         PARITY:  signal_d = even_parity(frame_d) ^ flip;
         default: signal_d = LINE_IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
      fail_d = (state_d == FAIL);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         frame_q   <= '0;
         bit_idx_q <= '0;
         retry_q   <= '0;
         timer_q   <= '0;
         signal_q  <= LINE_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fail_q    <= 1'b0;
`ifdef UART_TX_FAULT_INJECT_EN
         fault_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         bit_idx_q <= bit_idx_d;
         retry_q   <= retry_d;
         timer_q   <= timer_d;
         signal_q  <= signal_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         fail_q    <= fail_d;
`ifdef UART_TX_FAULT_INJECT_EN
         fault_q   <= fault_d;
`endif
      end
   end

   assign signal      = signal_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign fail        = fail_q;
   assign retry_count = retry_q;

endmodule

// File: tb/tb_uart_retrans_tx.sv
// Self-checking bench for uart_retrans_tx; frames are compared against a
// reference built from the byte value and the retry rules.
module tb_uart_retrans_tx;

   localparam int MAX_RETRY    = 4;
   localparam int RESP_TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       send;
   logic       ack;
   logic       request_resend;
`ifdef UART_TX_FAULT_INJECT_EN
   logic       inject_err;
`endif
   logic       signal;
   logic       busy;
   logic       done;
   logic       fail;
   logic [2:0] retry_count;

   int checks   = 0;
   int fails    = 0;
   int done_cnt = 0;
   int fail_cnt = 0;

   uart_retrans_tx #(
      .BIT_CYCLES  (1),
      .MAX_RETRY   (MAX_RETRY),
      .RESP_TIMEOUT(RESP_TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .data_in       (data_in),
      .send          (send),
      .ack           (ack),
      .request_resend(request_resend),
`ifdef UART_TX_FAULT_INJECT_EN
      .inject_err    (inject_err),
`endif
      .signal        (signal),
      .busy          (busy),
      .done          (done),
      .fail          (fail),
      .retry_count   (retry_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (done === 1'b1) done_cnt++;
      if (fail === 1'b1) fail_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   // Expected line levels, index 0 = start bit, 10 = stop bit.
   function automatic logic [10:0] ref_frame(input logic [7:0] b, input logic bad);
      int          ones;
      logic [10:0] f;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = b[i];
      f[9]  = 1'(ones % 2) ^ bad;
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic inj);
      data_in = b;
      send    = 1'b1;
`ifdef UART_TX_FAULT_INJECT_EN
      inject_err = inj;
`else
      if (inj) data_in = b;
`endif
      @(negedge clk);
      send    = 1'b0;
      data_in = 8'($urandom);
`ifdef UART_TX_FAULT_INJECT_EN
      inject_err = 1'b0;
`endif
   endtask

   task automatic capture_frame(output logic [10:0] fr);
      for (int i = 0; i < 11; i++) begin
         fr[i] = signal;
         @(negedge clk);
      end
   endtask

   task automatic respond(input int dly, input logic a, input logic r);
      repeat (dly) @(negedge clk);
      ack            = a;
      request_resend = r;
      @(negedge clk);
      ack            = 1'b0;
      request_resend = 1'b0;
   endtask

   task automatic wait_start(input int bound, output int idle, output logic found);
      idle = 0;
      while (signal === 1'b1 && idle < bound) begin
         @(negedge clk);
         idle++;
      end
      found = (signal === 1'b0);
   endtask

   task automatic test_reset;
      reset = 1'b1; send = 1'b0; ack = 1'b0; request_resend = 1'b0; data_in = '0;
`ifdef UART_TX_FAULT_INJECT_EN
      inject_err = 1'b0;
`endif
      repeat (3) @(negedge clk);
      checks++; if (signal !== 1'b1) begin fails++; $display("FAIL reset_signal: got %b expected 1", signal); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0 || fail !== 1'b0) begin fails++; $display("FAIL reset_pulses: got done=%b fail=%b expected 0/0", done, fail); end
      checks++; if (retry_count !== 3'd0) begin fails++; $display("FAIL reset_retry: got %0d expected 0", retry_count); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || signal !== 1'b1) begin fails++; $display("FAIL reset_release: got busy=%b signal=%b expected 0/1", busy, signal); end
   endtask

   task automatic test_basic;
      logic [10:0] fr;
      int d0;
      d0 = done_cnt;
      send_byte(8'hA5, 1'b0);
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b expected 1", busy); end
      capture_frame(fr);
      checks++; if (fr !== 11'b10101001010) begin fails++; $display("FAIL basic_line: got %b expected %b", fr, 11'b10101001010); end
      checks++; if (fr !== ref_frame(8'hA5, 1'b0)) begin fails++; $display("FAIL basic_model: got %b expected %b", fr, ref_frame(8'hA5, 1'b0)); end
      respond(1, 1'b1, 1'b0);
      checks++; if (done !== 1'b1) begin fails++; $display("FAIL basic_done: got %b expected 1", done); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL basic_idle: got busy=%b done=%b expected 0/0", busy, done); end
      checks++; if (done_cnt !== d0 + 1) begin fails++; $display("FAIL basic_done_count: got %0d expected %0d", done_cnt - d0, 1); end
      checks++; if (retry_count !== 3'd0) begin fails++; $display("FAIL basic_retry: got %0d expected 0", retry_count); end
   endtask

   task automatic test_resend;
      logic [10:0] fr1, fr2;
      int d0;
      d0 = done_cnt;
      send_byte(8'h07, 1'b0);
      capture_frame(fr1);
      respond(0, 1'b0, 1'b1);
      checks++; if (signal !== 1'b0) begin fails++; $display("FAIL resend_latency: got %b expected 0", signal); end
      checks++; if (retry_count !== 3'd1) begin fails++; $display("FAIL resend_retry_inc: got %0d expected 1", retry_count); end
      capture_frame(fr2);
      checks++; if (fr1 !== ref_frame(8'h07, 1'b0)) begin fails++; $display("FAIL resend_frame1: got %b expected %b", fr1, ref_frame(8'h07, 1'b0)); end
      checks++; if (fr2 !== fr1 || fr2[9] !== 1'b1) begin fails++; $display("FAIL resend_frame2: got %b expected %b", fr2, ref_frame(8'h07, 1'b0)); end
      respond($urandom_range(0, 5), 1'b1, 1'b0);
      checks++; if (done !== 1'b1) begin fails++; $display("FAIL resend_done: got %b expected 1", done); end
      @(negedge clk);
      checks++; if (done_cnt !== d0 + 1 || busy !== 1'b0) begin fails++; $display("FAIL resend_end: got done_count=%0d busy=%b expected 1/0", done_cnt - d0, busy); end
      checks++; if (retry_count !== 3'd1) begin fails++; $display("FAIL resend_retry_hold: got %0d expected 1", retry_count); end
   endtask

   task automatic test_timeout;
      logic [10:0] fr;
      logic        found;
      int          idle, n, d0, f0;
      d0 = done_cnt; f0 = fail_cnt;
      send_byte(8'h3C, 1'b0);
      capture_frame(fr);
      checks++; if (fr !== ref_frame(8'h3C, 1'b0)) begin fails++; $display("FAIL timeout_frame0: got %b expected %b", fr, ref_frame(8'h3C, 1'b0)); end
      for (int k = 1; k <= MAX_RETRY; k++) begin
         wait_start(40, idle, found);
         checks++; if (!found || idle != RESP_TIMEOUT) begin fails++; $display("FAIL timeout_gap%0d: got %0d idle cycles expected %0d", k, idle, RESP_TIMEOUT); end
         checks++; if (retry_count !== 3'(k)) begin fails++; $display("FAIL timeout_retry%0d: got %0d expected %0d", k, retry_count, k); end
         capture_frame(fr);
         checks++; if (fr !== ref_frame(8'h3C, 1'b0)) begin fails++; $display("FAIL timeout_frame%0d: got %b expected %b", k, fr, ref_frame(8'h3C, 1'b0)); end
      end
      n = 0;
      while (fail !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n != RESP_TIMEOUT) begin fails++; $display("FAIL timeout_fail_latency: got %0d expected %0d", n, RESP_TIMEOUT); end
      checks++; if (retry_count !== 3'(MAX_RETRY)) begin fails++; $display("FAIL timeout_retry_sat: got %0d expected %0d", retry_count, MAX_RETRY); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || fail_cnt !== f0 + 1 || done_cnt !== d0) begin fails++; $display("FAIL timeout_end: got busy=%b fails=%0d dones=%0d expected 0/1/0", busy, fail_cnt - f0, done_cnt - d0); end
   endtask

   task automatic test_ack_wins;
      logic [10:0] fr;
      logic        found;
      int          idle, d0;
      d0 = done_cnt;
      send_byte(8'h11, 1'b0);
      for (int i = 0; i < 11; i++) begin
         fr[i] = signal;
         if (i == 3) begin send = 1'b1; data_in = 8'hFF; end
         if (i == 6) send = 1'b0;
         @(negedge clk);
      end
      checks++; if (fr !== ref_frame(8'h11, 1'b0)) begin fails++; $display("FAIL busy_send_frame: got %b expected %b", fr, ref_frame(8'h11, 1'b0)); end
      respond(0, 1'b1, 1'b1);
      checks++; if (done !== 1'b1) begin fails++; $display("FAIL ack_wins_done: got %b expected 1", done); end
      @(negedge clk);
      wait_start(30, idle, found);
      checks++; if (found !== 1'b0) begin fails++; $display("FAIL ack_wins_no_resend: got start after %0d cycles expected none", idle); end
      checks++; if (busy !== 1'b0 || retry_count !== 3'd0 || done_cnt !== d0 + 1) begin fails++; $display("FAIL ack_wins_end: got busy=%b retry=%0d dones=%0d expected 0/0/1", busy, retry_count, done_cnt - d0); end
   endtask

   task automatic test_reset_mid_frame;
      logic [10:0] fr;
      logic [7:0]  b, b2;
      int          d0, f0;
      b = 8'($urandom); b2 = 8'($urandom);
      d0 = done_cnt; f0 = fail_cnt;
      send_byte(b, 1'b0);
      repeat (4) @(negedge clk);
      checks++; if (signal !== b[3]) begin fails++; $display("FAIL midreset_bit3: got %b expected %b", signal, b[3]); end
      #1 reset = 1'b1;
      #1;
      checks++; if (signal !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL midreset_async: got signal=%b busy=%b expected 1/0", signal, busy); end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (done_cnt !== d0 || fail_cnt !== f0) begin fails++; $display("FAIL midreset_pulses: got dones=%0d fails=%0d expected 0/0", done_cnt - d0, fail_cnt - f0); end
      send_byte(b2, 1'b0);
      capture_frame(fr);
      checks++; if (fr !== ref_frame(b2, 1'b0)) begin fails++; $display("FAIL midreset_resume: got %b expected %b", fr, ref_frame(b2, 1'b0)); end
      respond(2, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (done_cnt !== d0 + 1 || busy !== 1'b0) begin fails++; $display("FAIL midreset_done: got dones=%0d busy=%b expected 1/0", done_cnt - d0, busy); end
   endtask

`ifdef UART_TX_FAULT_INJECT_EN
   task automatic test_fault_inject;
      logic [10:0] fr;
      int d0;
      d0 = done_cnt;
      send_byte(8'h01, 1'b1);
      capture_frame(fr);
      checks++; if (fr !== ref_frame(8'h01, 1'b1) || fr[9] !== 1'b0) begin fails++; $display("FAIL inject_first: got %b expected %b", fr, ref_frame(8'h01, 1'b1)); end
      respond(1, 1'b0, 1'b1);
      capture_frame(fr);
      checks++; if (fr !== ref_frame(8'h01, 1'b0)) begin fails++; $display("FAIL inject_retry: got %b expected %b", fr, ref_frame(8'h01, 1'b0)); end
      respond(0, 1'b1, 1'b0);
      @(negedge clk);
      checks++; if (done_cnt !== d0 + 1) begin fails++; $display("FAIL inject_done: got %0d expected 1", done_cnt - d0); end
   endtask
`endif

   // Random bytes and resend counts; each byte is sent in the first IDLE cycle.
   task automatic test_back_to_back;
      logic [10:0] fr;
      logic [7:0]  b;
      logic        exp_done;
      int          r, d0, f0, exp_retry;
      for (int it = 0; it < 10; it++) begin
         b = 8'($urandom);
         r = $urandom_range(0, MAX_RETRY + 1);
         d0 = done_cnt; f0 = fail_cnt;
         send_byte(b, 1'b0);
         checks++; if (signal !== 1'b0) begin fails++; $display("FAIL b2b_accept%0d: got %b expected 0", it, signal); end
         for (int k = 0; k <= r && k <= MAX_RETRY; k++) begin
            capture_frame(fr);
            checks++; if (fr !== ref_frame(b, 1'b0)) begin fails++; $display("FAIL b2b_frame%0d_%0d: got %b expected %b", it, k, fr, ref_frame(b, 1'b0)); end
            if (k == r) begin
               respond($urandom_range(0, 10), 1'b1, 1'b0);
            end else begin
               respond($urandom_range(0, 10), 1'b0, 1'b1);
               if (k < MAX_RETRY) begin
                  checks++; if (retry_count !== 3'(k + 1)) begin fails++; $display("FAIL b2b_retry%0d_%0d: got %0d expected %0d", it, k, retry_count, k + 1); end
               end
            end
         end
         exp_done  = (r <= MAX_RETRY);
         exp_retry = (r < MAX_RETRY) ? r : MAX_RETRY;
         checks++; if (done !== exp_done || fail !== !exp_done) begin fails++; $display("FAIL b2b_outcome%0d: got done=%b fail=%b expected %b/%b", it, done, fail, exp_done, !exp_done); end
         @(negedge clk);
         checks++; if (busy !== 1'b0 || retry_count !== 3'(exp_retry)) begin fails++; $display("FAIL b2b_end%0d: got busy=%b retry=%0d expected 0/%0d", it, busy, retry_count, exp_retry); end
         checks++; if (done_cnt !== d0 + int'(exp_done) || fail_cnt !== f0 + int'(!exp_done)) begin fails++; $display("FAIL b2b_pulses%0d: got dones=%0d fails=%0d expected %0d/%0d", it, done_cnt - d0, fail_cnt - f0, exp_done, !exp_done); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_resend();
      test_timeout();
      test_ack_wins();
      test_reset_mid_frame();
`ifdef UART_TX_FAULT_INJECT_EN
      test_fault_inject();
`endif
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
